// File: rtl/sort_drv_pkg.sv
// Shared definitions for the insertion-sort driver.
// - state_e         : driver FSM states.
// - DefaultW/N      : default data width and words per frame.
// - order_violation : ordering test on operands pre-extended to CmpW bits.
package sort_drv_pkg;

    localparam int unsigned DefaultW = 32;
    localparam int unsigned DefaultN = 8;

    // One bit wider than the widest supported word, so both zero- and
    // sign-extended operands compare correctly as signed numbers.
    localparam int unsigned CmpW = 65;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic logic order_violation(input logic signed [CmpW-1:0] cur,
                                             input logic signed [CmpW-1:0] prev,
                                             input logic                   ascend);
        order_violation = ascend ? (cur < prev) : (cur > prev);
    endfunction

endpackage

// File: rtl/sort_order_checker.sv
// Order checker for words returned by the sorter.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   frame_start_i    clears the per-frame error flag
//   pop_i            a word is being consumed this cycle
//   has_prev_i       an earlier word of the same frame exists to compare to
//   cur_i            the word being consumed
//   frame_err_o      at least one violation in the current frame
//   err_cnt_o        saturating violation count since reset
module sort_order_checker
    import sort_drv_pkg::*;
#(
    parameter int unsigned W          = DefaultW,
    parameter bit          ASCEND     = 1'b1,
    parameter bit          SIGNED_CMP = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         frame_start_i,
    input  logic         pop_i,
    input  logic         has_prev_i,
    input  logic [W-1:0] cur_i,
    output logic         frame_err_o,
    output logic [15:0]  err_cnt_o
);

    logic [W-1:0]    prev_q, prev_d;
    logic            frame_err_q, frame_err_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic [CmpW-1:0] cur_ext, prev_ext;
    logic            violation;

    always_comb begin
        // Sign bit replicated only for two's-complement comparison.
        cur_ext   = {{(CmpW - W){SIGNED_CMP & cur_i[W-1]}}, cur_i};
        prev_ext  = {{(CmpW - W){SIGNED_CMP & prev_q[W-1]}}, prev_q};
        violation = pop_i && has_prev_i && order_violation(cur_ext, prev_ext, ASCEND);

        prev_d      = pop_i ? cur_i : prev_q;
        frame_err_d = frame_start_i ? 1'b0 : (frame_err_q | violation);
        err_cnt_d   = err_cnt_q;
        if (violation && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q      <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            prev_q      <= prev_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_err_o = frame_err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: rtl/insertion_sort_driver.sv
// Initiator for the insertion-sort pipeline: starts the sorter (ap_ctrl_hs),
// streams N upstream words into its input FIFO, drains N words from its
// output FIFO downstream and checks their order.
// Ports:
//   ap_clk, ap_rst_n                       clock, asynchronous active-low reset
//   run                                    launch a frame from idle
//   s_data/s_valid/s_ready                 upstream ready/valid source
//   sort_in_din/full_n/write               sorter input FIFO (writer side)
//   sort_out_dout/empty_n/read             sorter output FIFO (reader side)
//   sort_ap_start/ready/done               sorter block-level handshake
//   m_data/m_valid/m_last/m_ready          downstream ready/valid sink
//   frame_done, frame_err                  end-of-frame pulse and its error flag
//   err_cnt, frame_cnt                     violation and frame counters
module insertion_sort_driver
    import sort_drv_pkg::*;
#(
    parameter int unsigned N          = DefaultN,
    parameter int unsigned W          = DefaultW,
    parameter bit          ASCEND     = 1'b1,
    parameter bit          SIGNED_CMP = 1'b0
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    input  logic         run,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] sort_in_din,
    input  logic         sort_in_full_n,
    output logic         sort_in_write,
    input  logic [W-1:0] sort_out_dout,
    input  logic         sort_out_empty_n,
    output logic         sort_out_read,
    output logic         sort_ap_start,
    input  logic         sort_ap_ready,
    input  logic         sort_ap_done,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    output logic         m_last,
    input  logic         m_ready,
    output logic         frame_done,
    output logic         frame_err,
    output logic [15:0]  err_cnt,
    output logic [15:0]  frame_cnt
);

    localparam int unsigned     CntW    = $clog2(N + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(N);
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] send_cnt_q, send_cnt_d;
    logic [CntW-1:0] recv_cnt_q, recv_cnt_d;
    logic            ready_seen_q, ready_seen_d;
    logic            done_seen_q, done_seen_d;
    logic            start_q, start_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;

    logic in_run;
    logic frame_start;
    logic run_exit;
    logic chk_frame_err;

    assign in_run      = (state_q == StRun);
    assign frame_start = (state_q == StIdle) && run;

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. The exit test looks at next-state values so the frame
    // leaves RUN on the edge right after its last event.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (run) state_d = StRun;
            StRun:   if (run_exit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: zero-latency FIFO paths gated by state and counters.
    always_comb begin
        s_ready       = in_run && (send_cnt_q < FullCnt) && sort_in_full_n;
        sort_in_write = s_ready && s_valid;
        m_valid       = in_run && (recv_cnt_q < FullCnt) && sort_out_empty_n;
        sort_out_read = m_valid && m_ready;
        m_last        = m_valid && (recv_cnt_q == LastCnt);
        frame_done    = (state_q == StDone);
        frame_err     = frame_done && chk_frame_err;
    end

    assign sort_in_din   = s_data;
    assign m_data        = sort_out_dout;
    assign sort_ap_start = start_q;
    assign frame_cnt     = frame_cnt_q;

    // Counters and sticky handshake flags.
    always_comb begin
        send_cnt_d   = send_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        ready_seen_d = ready_seen_q;
        done_seen_d  = done_seen_q;
        if (frame_start) begin
            send_cnt_d   = '0;
            recv_cnt_d   = '0;
            ready_seen_d = 1'b0;
            done_seen_d  = 1'b0;
        end else if (in_run) begin
            if (sort_in_write) send_cnt_d = send_cnt_q + CntW'(1);
            if (sort_out_read) recv_cnt_d = recv_cnt_q + CntW'(1);
            if (sort_ap_ready) ready_seen_d = 1'b1;
            if (sort_ap_done)  done_seen_d  = 1'b1;
        end

        run_exit = (send_cnt_d == FullCnt) && (recv_cnt_d == FullCnt)
                   && ready_seen_d && done_seen_d;

        // ap_start rises with RUN entry and falls the cycle after ap_ready.
        start_d     = frame_start || (in_run && !ready_seen_d);
        frame_cnt_d = frame_cnt_q + {15'd0, (state_q == StDone)};
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            send_cnt_q   <= '0;
            recv_cnt_q   <= '0;
            ready_seen_q <= 1'b0;
            done_seen_q  <= 1'b0;
            start_q      <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            send_cnt_q   <= send_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            ready_seen_q <= ready_seen_d;
            done_seen_q  <= done_seen_d;
            start_q      <= start_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    sort_order_checker #(
        .W          (W),
        .ASCEND     (ASCEND),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_checker (
        .clk_i         (ap_clk),
        .rst_ni        (ap_rst_n),
        .frame_start_i (frame_start),
        .pop_i         (sort_out_read),
        .has_prev_i    (recv_cnt_q != '0),
        .cur_i         (sort_out_dout),
        .frame_err_o   (chk_frame_err),
        .err_cnt_o     (err_cnt)
    );

endmodule
